// File: rtl/de_aes_pkg.sv
// de_aes_pkg: shared AES inverse-cipher definitions (modes, state type, inverse S-box, GF(2^8) helpers).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package de_aes_pkg;

  // Round operation selector carried with every block.
  typedef enum logic [1:0] {
    MODE_MID   = 2'd0,
    MODE_FINAL = 2'd1,
    MODE_INIT  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // 16-byte state; element 0 is the most significant byte ([127:120]), column-major.
  typedef logic [0:15][7:0] state_t;

  // Inverse S-box; entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x (0x02) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4], byte index = 4*c + r.
  function automatic state_t inv_shift_rows(input state_t s);
    return {s[0],  s[13], s[10], s[7],
            s[4],  s[1],  s[14], s[11],
            s[8],  s[5],  s[2],  s[15],
            s[12], s[9],  s[6],  s[3]};
  endfunction

endpackage

// File: rtl/de_inv_mixcol.sv
// de_inv_mixcol: InvMixColumns on one 32-bit state column (row 0 byte in [31:24]).
// Latency 0, purely combinational.
// No flow control; the enclosing pipeline stage owns backpressure.
module de_inv_mixcol
  import de_aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0;
  logic [7:0] w_a1;
  logic [7:0] w_a2;
  logic [7:0] w_a3;

  assign {w_a0, w_a1, w_a2, w_a3} = i_col;

  // Circulant matrix rows: {0e 0b 0d 09} rotated right once per output byte.
  assign o_col = {gmul0e(w_a0) ^ gmul0b(w_a1) ^ gmul0d(w_a2) ^ gmul09(w_a3),
                  gmul09(w_a0) ^ gmul0e(w_a1) ^ gmul0b(w_a2) ^ gmul0d(w_a3),
                  gmul0d(w_a0) ^ gmul09(w_a1) ^ gmul0e(w_a2) ^ gmul0b(w_a3),
                  gmul0b(w_a0) ^ gmul0d(w_a1) ^ gmul09(w_a2) ^ gmul0e(w_a3)};

endmodule

// File: rtl/de_round_pipe.sv
// de_round_pipe: one AES inverse-cipher round (middle or final) per block, key and tag travel with it.
// Latency 1 + SBOX_REG cycles, one block per cycle; define DE_ROUND_INITIAL_EN to enable mode 2 (key-add only).
// Single global stall: every stage advances only while the output is empty or being taken (oReady = advance).
module de_round_pipe
  import de_aes_pkg::*;
#(
  parameter int SBOX_REG = 1,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [127:0]     iBlockIn,
  input  logic [127:0]     iKeyValue,
  input  logic [1:0]       iMode,
  input  logic [TAG_W-1:0] iTag,
  output logic             oValid,
  input  logic             iReady,
  output logic [127:0]     oBlockout,
  output logic [TAG_W-1:0] oTag,
  output logic             oModeErr
);

  logic             w_advance;
  logic             w_accept;
  mode_e            w_mode;
  logic             w_mode_bad;
  state_t           w_sr;
  state_t           w_sb;
  state_t           w_front;

  // Signals entering the output stage (from stage S or straight from the input).
  logic             w_st_vld;
  state_t           w_st_dat;
  logic [127:0]     w_st_key;
  mode_e            w_st_mode;
  logic [TAG_W-1:0] w_st_tag;

  logic [127:0]     w_x;
  logic [127:0]     w_mc;
  logic [127:0]     w_result;

  logic             r_o_vld;
  logic [127:0]     r_o_dat;
  logic [TAG_W-1:0] r_o_tag;
  logic             r_mode_err;

  assign w_advance = !r_o_vld || iReady;
  assign w_accept  = iValid && w_advance;
  assign oReady    = w_advance;

  // Translate the requested mode into the operation performed; illegal modes run as final.
  always_comb begin
    w_mode     = MODE_FINAL;
    w_mode_bad = 1'b0;
    case (iMode)
      MODE_MID:   w_mode = MODE_MID;
      MODE_FINAL: w_mode = MODE_FINAL;
`ifdef DE_ROUND_INITIAL_EN
      MODE_INIT:  w_mode = MODE_INIT;
`endif
      default:    w_mode_bad = 1'b1;
    endcase
  end

  assign w_sr = inv_shift_rows(iBlockIn);

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign w_sb[gi] = INV_SBOX[w_sr[gi]];
  end

`ifdef DE_ROUND_INITIAL_EN
  // The initial round bypasses shift and S-box but still walks the same stages for uniform latency.
  assign w_front = (w_mode == MODE_INIT) ? state_t'(iBlockIn) : w_sb;
`else
  assign w_front = w_sb;
`endif

  if (SBOX_REG != 0) begin : g_sreg
    logic             r_s_vld;
    state_t           r_s_dat;
    logic [127:0]     r_s_key;
    mode_e            r_s_mode;
    logic [TAG_W-1:0] r_s_tag;

    // Stage S: capture the substituted state with its own key, mode and tag.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s_vld  <= 1'b0;
        r_s_dat  <= '0;
        r_s_key  <= '0;
        r_s_mode <= MODE_MID;
        r_s_tag  <= '0;
      end else if (w_advance) begin
        r_s_vld <= iValid;
        if (iValid) begin
          r_s_dat  <= w_front;
          r_s_key  <= iKeyValue;
          r_s_mode <= w_mode;
          r_s_tag  <= iTag;
        end
      end
    end

    assign w_st_vld  = r_s_vld;
    assign w_st_dat  = r_s_dat;
    assign w_st_key  = r_s_key;
    assign w_st_mode = r_s_mode;
    assign w_st_tag  = r_s_tag;
  end else begin : g_scomb
    assign w_st_vld  = iValid;
    assign w_st_dat  = w_front;
    assign w_st_key  = iKeyValue;
    assign w_st_mode = w_mode;
    assign w_st_tag  = iTag;
  end

  assign w_x = w_st_dat ^ w_st_key;

  for (genvar gc = 0; gc < 4; gc++) begin : g_mixcol
    de_inv_mixcol u_mixcol (
      .i_col (w_x[127-32*gc -: 32]),
      .o_col (w_mc[127-32*gc -: 32])
    );
  end

  assign w_result = (w_st_mode == MODE_MID) ? w_mc : w_x;

  // Output stage: load on advance, otherwise hold so the block stays stable under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_vld <= 1'b0;
      r_o_dat <= '0;
      r_o_tag <= '0;
    end else if (w_advance) begin
      r_o_vld <= w_st_vld;
      if (w_st_vld) begin
        r_o_dat <= w_result;
        r_o_tag <= w_st_tag;
      end
    end
  end

  // Mode error: single-cycle pulse following the accept of an illegal-mode block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_err <= 1'b0;
    end else begin
      r_mode_err <= w_accept && w_mode_bad;
    end
  end

  assign oValid    = r_o_vld;
  assign oBlockout = r_o_dat;
  assign oTag      = r_o_tag;
  assign oModeErr  = r_mode_err;

endmodule

// File: tb/tb_de_round_pipe.sv
// tb_de_round_pipe: directed checks of de_round_pipe at SBOX_REG=0 and SBOX_REG=1 side by side.
// Latency expectations are 1 and 2 cycles respectively.
// Exercises stall/backpressure, reset mid-flight and mode error handling.
module tb_de_round_pipe;

  logic         clk;
  logic         rst;
  logic         iValid_a   [2];
  logic         oReady_a   [2];
  logic [127:0] blk_a      [2];
  logic [127:0] key_a      [2];
  logic [1:0]   mode_a     [2];
  logic [7:0]   tag_a      [2];
  logic         oValid_a   [2];
  logic         iReady_a   [2];
  logic [127:0] out_a      [2];
  logic [7:0]   otag_a     [2];
  logic         oModeErr_a [2];

  int total;
  int bad;

  localparam logic [127:0] ALL63 = {16{8'h63}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    de_round_pipe #(.SBOX_REG(g), .TAG_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .iValid    (iValid_a[g]),
      .oReady    (oReady_a[g]),
      .iBlockIn  (blk_a[g]),
      .iKeyValue (key_a[g]),
      .iMode     (mode_a[g]),
      .iTag      (tag_a[g]),
      .oValid    (oValid_a[g]),
      .iReady    (iReady_a[g]),
      .oBlockout (out_a[g]),
      .oTag      (otag_a[g]),
      .oModeErr  (oModeErr_a[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      total++; if (oValid_a[d] !== 1'b0) begin bad++; $display("FAIL rst_valid sr=%0d got=%b want=0", d, oValid_a[d]); end
      total++; if (out_a[d] !== 128'h0) begin bad++; $display("FAIL rst_block sr=%0d got=%h want=0", d, out_a[d]); end
      total++; if (otag_a[d] !== 8'h00) begin bad++; $display("FAIL rst_tag sr=%0d got=%h want=00", d, otag_a[d]); end
      total++; if (oModeErr_a[d] !== 1'b0) begin bad++; $display("FAIL rst_moderr sr=%0d got=%b want=0", d, oModeErr_a[d]); end
      total++; if (oReady_a[d] !== 1'b1) begin bad++; $display("FAIL rst_ready sr=%0d got=%b want=1", d, oReady_a[d]); end
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_final(input int d);
    int lat;
    lat = d + 1;
    iValid_a[d] = 1'b1;
    blk_a[d]    = 128'h6353e08c0960e104cd70b751bacad0e7;
    key_a[d]    = 128'h000102030405060708090a0b0c0d0e0f;
    mode_a[d]   = 2'd1;
    tag_a[d]    = 8'hc1;
    tick();
    iValid_a[d] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      total++; if (oValid_a[d] !== 1'b0) begin bad++; $display("FAIL final_early sr=%0d got=%b want=0", d, oValid_a[d]); end
      tick();
    end
    total++; if (oValid_a[d] !== 1'b1) begin bad++; $display("FAIL final_valid sr=%0d got=%b want=1", d, oValid_a[d]); end
    total++; if (out_a[d] !== 128'h00112233445566778899aabbccddeeff) begin bad++; $display("FAIL final_block sr=%0d got=%h want=00112233445566778899aabbccddeeff", d, out_a[d]); end
    total++; if (otag_a[d] !== 8'hc1) begin bad++; $display("FAIL final_tag sr=%0d got=%h want=c1", d, otag_a[d]); end
    total++; if (oModeErr_a[d] !== 1'b0) begin bad++; $display("FAIL final_moderr sr=%0d got=%b want=0", d, oModeErr_a[d]); end
    tick();
    total++; if (oValid_a[d] !== 1'b0) begin bad++; $display("FAIL final_drain sr=%0d got=%b want=0", d, oValid_a[d]); end
  endtask

  task automatic test_middle(input int d);
    int lat;
    lat = d + 1;
    iValid_a[d] = 1'b1;
    blk_a[d]    = ALL63;
    key_a[d]    = {4{32'h8e4da1bc}};
    mode_a[d]   = 2'd0;
    tag_a[d]    = 8'h3d;
    tick();
    iValid_a[d] = 1'b0;
    for (int k = 1; k < lat; k++) tick();
    total++; if (oValid_a[d] !== 1'b1) begin bad++; $display("FAIL middle_valid sr=%0d got=%b want=1", d, oValid_a[d]); end
    total++; if (out_a[d] !== {4{32'hdb135345}}) begin bad++; $display("FAIL middle_block sr=%0d got=%h want=%h", d, out_a[d], {4{32'hdb135345}}); end
    total++; if (otag_a[d] !== 8'h3d) begin bad++; $display("FAIL middle_tag sr=%0d got=%h want=3d", d, otag_a[d]); end
    tick();
  endtask

  task automatic test_modes(input int d);
    int lat;
    logic [1:0]   t_mode [3];
    logic [127:0] t_blk  [3];
    logic [127:0] t_key  [3];
    logic [127:0] t_exp  [3];
    logic         t_err  [3];
    lat = d + 1;
    t_mode[0] = 2'd3; t_blk[0] = ALL63; t_key[0] = 128'h0123456789abcdeffedcba9876543210;
    t_exp[0]  = 128'h0123456789abcdeffedcba9876543210; t_err[0] = 1'b1;
`ifdef DE_ROUND_INITIAL_EN
    t_mode[1] = 2'd2; t_blk[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; t_key[1] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    t_exp[1]  = 128'h7ad5fda789ef4e272bca100b3d9ff59f; t_err[1] = 1'b0;
`else
    t_mode[1] = 2'd2; t_blk[1] = ALL63; t_key[1] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    t_exp[1]  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0; t_err[1] = 1'b1;
`endif
    t_mode[2] = 2'd1; t_blk[2] = ALL63; t_key[2] = 128'h55aa55aa00ff00ff1234567890abcdef;
    t_exp[2]  = 128'h55aa55aa00ff00ff1234567890abcdef; t_err[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iValid_a[d] = 1'b1;
      blk_a[d]    = t_blk[i];
      key_a[d]    = t_key[i];
      mode_a[d]   = t_mode[i];
      tag_a[d]    = 8'(8'h80 + i);
      tick();
      iValid_a[d] = 1'b0;
      total++; if (oModeErr_a[d] !== t_err[i]) begin bad++; $display("FAIL mode_err_pulse sr=%0d mode=%0d got=%b want=%b", d, t_mode[i], oModeErr_a[d], t_err[i]); end
      for (int k = 1; k < lat; k++) tick();
      total++; if (oValid_a[d] !== 1'b1 || out_a[d] !== t_exp[i]) begin bad++; $display("FAIL mode_block sr=%0d mode=%0d got=%b/%h want=1/%h", d, t_mode[i], oValid_a[d], out_a[d], t_exp[i]); end
      tick();
      total++; if (oModeErr_a[d] !== 1'b0 || oValid_a[d] !== 1'b0) begin bad++; $display("FAIL mode_after sr=%0d mode=%0d err=%b valid=%b want=0/0", d, t_mode[i], oModeErr_a[d], oValid_a[d]); end
    end
  endtask

  task automatic test_back_to_back(input int d);
    int lat;
    logic [7:0] kb;
    logic       exp_v;
    lat = d + 1;
    iReady_a[d] = 1'b1;
    for (int c = 0; c < 8 + lat + 2; c++) begin
      if (c < 8) begin
        iValid_a[d] = 1'b1;
        blk_a[d]    = ALL63;
        key_a[d]    = {16{8'(8'h30 + c)}};
        mode_a[d]   = 2'd1;
        tag_a[d]    = 8'(8'h20 + c);
      end else begin
        iValid_a[d] = 1'b0;
      end
      #1;
      total++; if (oReady_a[d] !== 1'b1) begin bad++; $display("FAIL b2b_ready sr=%0d cyc=%0d got=%b want=1", d, c, oReady_a[d]); end
      exp_v = (c >= lat) && (c < 8 + lat);
      total++; if (oValid_a[d] !== exp_v) begin bad++; $display("FAIL b2b_valid sr=%0d cyc=%0d got=%b want=%b", d, c, oValid_a[d], exp_v); end
      if (exp_v) begin
        kb = 8'(8'h30 + (c - lat));
        total++;
        if (otag_a[d] !== 8'(8'h20 + (c - lat)) || out_a[d] !== {16{kb}}) begin
          bad++; $display("FAIL b2b_data sr=%0d cyc=%0d got=%h/%h want=%h/%h", d, c, otag_a[d], out_a[d], 8'(8'h20 + (c - lat)), {16{kb}});
        end
      end
      tick();
    end
  endtask

  task automatic test_stream(input int d);
    int           sent;
    int           recv;
    logic         acc;
    logic         stl;
    logic [127:0] hb;
    logic [7:0]   ht;
    logic [7:0]   kb;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 100 && recv < 8; c++) begin
      iReady_a[d] = ((c % 4) == 0) || ((c % 4) == 3);
      if (sent < 8) begin
        iValid_a[d] = 1'b1;
        blk_a[d]    = ALL63;
        key_a[d]    = {16{8'(8'h40 + sent)}};
        mode_a[d]   = 2'd1;
        tag_a[d]    = 8'(8'h50 + sent);
      end else begin
        iValid_a[d] = 1'b0;
      end
      #1;
      acc = iValid_a[d] && oReady_a[d];
      if (oValid_a[d] && iReady_a[d]) begin
        kb = 8'(8'h40 + recv);
        total++;
        if (out_a[d] !== {16{kb}} || otag_a[d] !== 8'(8'h50 + recv)) begin
          bad++; $display("FAIL stream_data sr=%0d idx=%0d got=%h/%h want=%h/%h", d, recv, otag_a[d], out_a[d], 8'(8'h50 + recv), {16{kb}});
        end
        recv++;
      end
      stl = oValid_a[d] && !iReady_a[d];
      hb  = out_a[d];
      ht  = otag_a[d];
      tick();
      if (acc) sent++;
      if (stl) begin
        total++;
        if (oValid_a[d] !== 1'b1 || out_a[d] !== hb || otag_a[d] !== ht) begin
          bad++; $display("FAIL stream_hold sr=%0d got=%b/%h/%h want=1/%h/%h", d, oValid_a[d], otag_a[d], out_a[d], ht, hb);
        end
      end
    end
    total++; if (recv !== 8) begin bad++; $display("FAIL stream_count sr=%0d got=%0d want=8", d, recv); end
    iValid_a[d] = 1'b0;
    iReady_a[d] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (oValid_a[d] !== 1'b0) begin bad++; $display("FAIL stream_extra sr=%0d cyc=%0d got=%b want=0", d, k, oValid_a[d]); end
      tick();
    end
  endtask

  task automatic test_reset_midflight(input int d);
    int lat;
    lat = d + 1;
    iReady_a[d] = 1'b0;
    iValid_a[d] = 1'b1;
    blk_a[d]    = ALL63;
    key_a[d]    = {16{8'h71}};
    mode_a[d]   = 2'd3;
    tag_a[d]    = 8'h71;
    tick();
    key_a[d]    = {16{8'h72}};
    mode_a[d]   = 2'd1;
    tag_a[d]    = 8'h72;
    tick();
    iValid_a[d] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (oValid_a[d] !== 1'b0) begin bad++; $display("FAIL midrst_valid sr=%0d got=%b want=0", d, oValid_a[d]); end
    total++; if (out_a[d] !== 128'h0 || otag_a[d] !== 8'h00) begin bad++; $display("FAIL midrst_data sr=%0d got=%h/%h want=0/0", d, otag_a[d], out_a[d]); end
    total++; if (oModeErr_a[d] !== 1'b0) begin bad++; $display("FAIL midrst_moderr sr=%0d got=%b want=0", d, oModeErr_a[d]); end
    tick();
    tick();
    rst = 1'b0;
    iReady_a[d] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (oValid_a[d] !== 1'b0) begin bad++; $display("FAIL midrst_stale sr=%0d cyc=%0d got=%b want=0", d, k, oValid_a[d]); end
      tick();
    end
    iValid_a[d] = 1'b1;
    key_a[d]    = {16{8'h9c}};
    mode_a[d]   = 2'd1;
    tag_a[d]    = 8'h73;
    tick();
    iValid_a[d] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      total++; if (oValid_a[d] !== 1'b0) begin bad++; $display("FAIL midrst_early sr=%0d got=%b want=0", d, oValid_a[d]); end
      tick();
    end
    total++;
    if (oValid_a[d] !== 1'b1 || out_a[d] !== {16{8'h9c}} || otag_a[d] !== 8'h73) begin
      bad++; $display("FAIL midrst_next sr=%0d got=%b/%h/%h want=1/73/%h", d, oValid_a[d], otag_a[d], out_a[d], {16{8'h9c}});
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iValid_a[i] = 1'b0;
      iReady_a[i] = 1'b1;
      blk_a[i]    = '0;
      key_a[i]    = '0;
      mode_a[i]   = 2'd0;
      tag_a[i]    = 8'h00;
    end
    #1;
    rst = 1'b1;
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_final(d);
      test_middle(d);
      test_modes(d);
      test_back_to_back(d);
      test_stream(d);
      test_reset_midflight(d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/de_round_pipe.md
Name: de_round_pipe

Overview:
- Parametrised AES decryption round engine for the inverse-cipher datapath.
- Executes either a middle round or the final round, selected per transaction:
  - middle: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
  - final: InvShiftRows, InvSubBytes, AddRoundKey
- Adds a valid/ready handshake with backpressure, a configurable pipeline depth and a sideband tag.
- Sits between the round-key schedule and the round sequencer. Several instances are chained or looped for iterative decryption.

Parameters:
- SBOX_REG, 1, 1 inserts a register after InvSubBytes; 0 makes the S-box combinational. Latency LAT = 1 + SBOX_REG.
- TAG_W, 8, width of the sideband tag carried alongside each block.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iValid  in  1  input block/key/mode valid.
- oReady  out  1  engine accepts input this cycle.
- iBlockIn  in  128  state; byte 0 at [127:120], column-major per FIPS-197.
- iKeyValue  in  128  round key for this transaction.
- iMode  in  2  0 = middle, 1 = final, 2 = initial (macro only), 3 = reserved.
- iTag  in  TAG_W  sideband, returned unchanged.
- oValid  out  1  output valid.
- iReady  in  1  downstream accepts output.
- oBlockout  out  128  round result.
- oTag  out  TAG_W  tag of the output block.
- oModeErr  out  1  one-cycle pulse when a reserved or disabled mode is accepted.

Behaviour:
- Reset: every stage valid bit, oValid, oBlockout, oTag and oModeErr go to 0 immediately on assertion of rst. Reset mid-operation drops all in-flight blocks without producing output.
- Pipeline advance: advance = !oValid || iReady, a single global stall.
  - oReady = advance.
  - An input is accepted when iValid && oReady.
- Latency: a block accepted at cycle t appears with oValid at t+LAT when not stalled. Under stall, the stages hold data and valid bits unchanged.
- Per-stage state: block, key, mode and tag move together. The key is captured with its block, so iKeyValue may change every cycle.
- Stage S (present only when SBOX_REG=1): holds InvSubBytes(InvShiftRows(block)), plus key, mode and tag.
- Output stage:
  - x = sbox_result ^ key.
  - Mode middle: oBlockout = InvMixColumns(x), computed over GF(2^8) with polynomial 0x11B and coefficients 0e, 0b, 0d, 09.
  - Mode final: oBlockout = x.
- InvShiftRows: row r rotates right by r bytes.
- Output holds stable while oValid && !iReady (AXI-style). oValid must not drop without a handshake.
- Throughput: one block per cycle when iReady is held high; no bubbles.
- Simultaneous accept and output handshake in the same cycle is legal and is the normal streaming case.
- Invalid mode (3, or 2 without the macro): the block is processed as final. oModeErr pulses one cycle when that block is accepted.
- Pipeline bubbles (input valid low while advancing) propagate as invalid stages.

Optional Feature:
- Macro: DE_ROUND_INITIAL_EN.
- Defined: mode 2 (initial round) is legal. oBlockout = iBlockIn ^ key. The S-box and shift are bypassed; the block is still delayed through LAT stages so latency stays uniform. oModeErr is not raised for mode 2.
- Undefined: mode 2 is treated as reserved (final behaviour plus oModeErr). The bypass mux is absent.

Decomposition:
- Shared package de_aes_pkg holds:
  - mode constants MODE_MID, MODE_FINAL, MODE_INIT
  - the 256-entry inverse S-box constant
  - the xtime / gmul functions for coefficients 09, 0b, 0d, 0e
- One natural sub-module: de_inv_mixcol, combinational, 32-bit column in and out. It is instantiated four times.

Test Plan:
- Final round, FIPS-197 C.1: mode=1, block 6353e08c0960e104cd70b751bacad0e7, key 000102030405060708090a0b0c0d0e0f -> oBlockout 00112233445566778899aabbccddeeff at t+LAT, tag echoed.
- Middle round: mode=0, block 63636363...63 (all bytes 0x63), key 8e4da1bc repeated in 4 columns -> oBlockout db135345db135345db135345db135345.
- Streaming with backpressure: 8 back-to-back blocks with distinct tags, iReady toggled 1,0,0,1,... -> all 8 emerge in order, none lost or duplicated, output stable while stalled. With iReady=1, a full rate of 1/cycle is sustained.
- Reset mid-flight: assert rst with 2 blocks in the pipe -> oValid=0 immediately. After release, no stale block appears; the next accepted block exits at t+LAT.
- Mode handling: mode=3, then mode=2 -> oModeErr pulses on both without DE_ROUND_INITIAL_EN. With the macro, mode=2, block 69c4e0d86a7b0430d8cdb78070b4c55a, key 13111d7fe3944a17f307a78b4d2b30c5 -> 7ad5fda789ef4e272bca100b3d9ff59f, with no error.
- Run all scenarios at SBOX_REG=0 and SBOX_REG=1 -> identical results, latency 1 vs 2.
